// File: rtl/ro_puf_pkg.sv
// rtl/ro_puf_pkg.sv - state encoding and timing constants shared by the RO PUF engine
`timescale 1ns/1ps
package ro_puf_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_MEASURE,
    ST_COMPARE,
    ST_DONE
  } ro_puf_state_t;

  localparam int SETTLE_CYCLES = 4;
  localparam int MAJ_REPEATS   = 3;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/ro_edge_counter.sv
// rtl/ro_edge_counter.sv - synchronises one raw oscillator and counts its rising edges, saturating
`timescale 1ns/1ps
module ro_edge_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ro,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  logic [1:0] sync;
  logic       prev;
  logic       rise;

  assign rise = sync[1] & ~prev;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync  <= '0;
      prev  <= 1'b0;
      count <= '0;
    end else begin
      sync <= {sync[0], ro};
      prev <= sync[1];
      if (clr) begin
        count <= '0;
      end else if (en && rise && (count != {CNT_W{1'b1}})) begin
        count <= count + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/ro_puf_engine.sv
// rtl/ro_puf_engine.sv - windowed ring-oscillator pair comparison building a RESP_BITS response
// Define RO_PUF_MAJORITY_EN to measure each pair three times and take the majority bit.
`timescale 1ns/1ps
module ro_puf_engine
  import ro_puf_pkg::*;
#(
  parameter int NUM_RO    = 16,
  parameter int CNT_W     = 16,
  parameter int WIN_W     = 12,
  parameter int RESP_BITS = 8,
  localparam int SEL_W    = $clog2(NUM_RO)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic [NUM_RO-1:0]    ro_in,
  input  logic                 start,
  input  logic [SEL_W-1:0]     sel_a,
  input  logic [SEL_W-1:0]     sel_b,
  input  logic [WIN_W-1:0]     window,
  output logic                 busy,
  output logic                 resp_valid,
  output logic [RESP_BITS-1:0] response,
  output logic                 tie,
  output logic [CNT_W-1:0]     count_a,
  output logic [CNT_W-1:0]     count_b
);

  localparam int K_W = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
  localparam logic [WIN_W-1:0] SETTLE_LAST = WIN_W'(SETTLE_CYCLES - 1);
  localparam logic [K_W-1:0]   K_LAST      = K_W'(RESP_BITS - 1);

  ro_puf_state_t state, state_nxt;

  logic [SEL_W-1:0]     base_a, base_b, idx_a, idx_b;
  logic [WIN_W-1:0]     win_q, tmr;
  logic [K_W-1:0]       k;
  logic [RESP_BITS-1:0] resp_sh, resp_next;
  logic                 tie_sh;
  logic [CNT_W-1:0]     cnt_a, cnt_b;
  logic                 gt, eq, bit_val, last_rep;
  logic                 cnt_clr, cnt_en;

  // Pair index wraps by natural SEL_W overflow since NUM_RO is a power of two.
  assign idx_a = base_a + SEL_W'(k);
  assign idx_b = base_b + SEL_W'(k);

  ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_a (
    .clk   (clk),
    .rst_n (rst_n),
    .ro    (ro_in[idx_a]),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .count (cnt_a)
  );

  ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_b (
    .clk   (clk),
    .rst_n (rst_n),
    .ro    (ro_in[idx_b]),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .count (cnt_b)
  );

  assign gt = cnt_a > cnt_b;
  assign eq = cnt_a == cnt_b;

`ifdef RO_PUF_MAJORITY_EN
  logic [1:0] rep;
  logic [1:0] votes;

  assign last_rep = (rep == 2'(MAJ_REPEATS - 1));
  assign bit_val  = maj3(votes[1], votes[0], gt);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rep   <= '0;
      votes <= '0;
    end else if (state == ST_IDLE) begin
      rep <= '0;
    end else if (state == ST_COMPARE && ena) begin
      votes <= {votes[0], gt};
      rep   <= last_rep ? 2'd0 : rep + 2'd1;
    end
  end
`else
  assign last_rep = 1'b1;
  assign bit_val  = gt;
`endif

  always_comb begin
    resp_next = resp_sh;
    for (int i = 0; i < RESP_BITS; i++) begin
      if (K_W'(i) == k) resp_next[i] = bit_val;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b1;
    cnt_en    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && ena) state_nxt = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (tmr == SETTLE_LAST) state_nxt = ST_MEASURE;
      end
      ST_MEASURE: begin
        cnt_clr = 1'b0;
        cnt_en  = 1'b1;
        if (tmr == win_q - WIN_W'(1)) state_nxt = ST_COMPARE;
      end
      ST_COMPARE: begin
        cnt_clr = 1'b0;
        if (last_rep && k == K_LAST) state_nxt = ST_DONE;
        else                         state_nxt = ST_SETTLE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    if (!ena && state != ST_IDLE) state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Bits assemble in a shadow so an aborted run leaves the last completed response visible.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      base_a   <= '0;
      base_b   <= '0;
      win_q    <= '0;
      tmr      <= '0;
      k        <= '0;
      resp_sh  <= '0;
      tie_sh   <= 1'b0;
      response <= '0;
      tie      <= 1'b0;
      count_a  <= '0;
      count_b  <= '0;
    end else begin
      if (state_nxt != state) tmr <= '0;
      else                    tmr <= tmr + WIN_W'(1);
      case (state)
        ST_IDLE: begin
          if (start && ena) begin
            base_a <= sel_a;
            base_b <= sel_b;
            win_q  <= (window == '0) ? WIN_W'(1) : window;
            k      <= '0;
            tie_sh <= 1'b0;
          end
        end
        ST_COMPARE: begin
          if (ena) begin
            count_a <= cnt_a;
            count_b <= cnt_b;
            if (eq) tie_sh <= 1'b1;
            if (last_rep) begin
              resp_sh <= resp_next;
              if (k == K_LAST) begin
                response <= resp_next;
                tie      <= tie_sh | eq;
              end else begin
                k <= k + K_W'(1);
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy       = (state == ST_SETTLE) || (state == ST_MEASURE) || (state == ST_COMPARE);
  assign resp_valid = (state == ST_DONE);

endmodule

// File: tb/tb_ro_puf_engine.sv
// tb/tb_ro_puf_engine.sv - scoreboard bench for ro_puf_engine driven by free-running RO models
`timescale 1ns/1ps
module tb_ro_puf_engine;

  // Oscillator periods in time units; the clock period is 10.
  localparam int RO_P [16] = '{50, 30, 70, 40, 90, 80, 36, 60, 100, 32, 44, 70, 140, 56, 100, 44};

  logic        clk = 1'b0;
  logic        rst_n, ena, start;
  logic [3:0]  sel_a, sel_b;
  logic [11:0] window;
  wire  [15:0] ro_in;

  logic        m_busy, m_valid, m_tie;
  logic [7:0]  m_resp;
  logic [15:0] m_cnt_a, m_cnt_b;
  logic        o_busy, o_valid, o_tie;
  logic [0:0]  o_resp;
  logic [15:0] o_cnt_a, o_cnt_b;
  logic        s_busy, s_valid, s_tie;
  logic [0:0]  s_resp;
  logic [3:0]  s_cnt_a, s_cnt_b;

  int errors = 0;
  int checks = 0;
  int edge_n = 0;
  int acc    = 0;

  typedef struct {
    logic [7:0] resp;
    logic       tie;
    int         lat;
    int         acc;
    logic       same;
  } exp_t;
  exp_t exp_q[$];
  exp_t e_cur;

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  for (genvar g = 0; g < 16; g++) begin : g_ro
    logic r = 1'b0;
    initial begin
      #(g + 1);
      forever #(RO_P[g] / 2) r = ~r;
    end
    assign ro_in[g] = r;
  end

  ro_puf_engine #(.NUM_RO(16), .CNT_W(16), .WIN_W(12), .RESP_BITS(8)) u_main (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ro_in(ro_in), .start(start),
    .sel_a(sel_a), .sel_b(sel_b), .window(window),
    .busy(m_busy), .resp_valid(m_valid), .response(m_resp), .tie(m_tie),
    .count_a(m_cnt_a), .count_b(m_cnt_b)
  );

  ro_puf_engine #(.NUM_RO(16), .CNT_W(16), .WIN_W(12), .RESP_BITS(1)) u_one (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ro_in(ro_in), .start(start),
    .sel_a(sel_a), .sel_b(sel_b), .window(window),
    .busy(o_busy), .resp_valid(o_valid), .response(o_resp), .tie(o_tie),
    .count_a(o_cnt_a), .count_b(o_cnt_b)
  );

  ro_puf_engine #(.NUM_RO(16), .CNT_W(4), .WIN_W(12), .RESP_BITS(1)) u_sat (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ro_in(ro_in), .start(start),
    .sel_a(sel_a), .sel_b(sel_b), .window(window),
    .busy(s_busy), .resp_valid(s_valid), .response(s_resp), .tie(s_tie),
    .count_a(s_cnt_a), .count_b(s_cnt_b)
  );

  task automatic check_eq(input string tag, input longint got, input longint want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  function automatic logic [7:0] model(input int a, input int b);
    logic [7:0] r;
    for (int k = 0; k < 8; k++) r[k] = RO_P[(a + k) % 16] < RO_P[(b + k) % 16];
    return r;
  endfunction

  task automatic kick(input int a, input int b, input int w);
    @(negedge clk);
    sel_a  = 4'(a);
    sel_b  = 4'(b);
    window = 12'(w);
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    acc   = edge_n;
  endtask

  task automatic push_main(input int a, input int b, input int w);
    exp_t e;
    int   we;
    we     = (w == 0) ? 1 : w;
    e.resp = model(a, b);
    e.tie  = (a == b);
    e.lat  = 8 * (we + 5);
    e.acc  = acc;
    e.same = (a == b);
    exp_q.push_back(e);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      check_eq("main_valid_timeout", 0, 1);
      exp_q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (rst_n && m_valid) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_valid", 1, 0);
      end else begin
        e_cur = exp_q.pop_front();
        check_eq("main_response", m_resp, e_cur.resp);
        check_eq("main_tie", m_tie, e_cur.tie);
        check_eq("main_latency", edge_n - e_cur.acc, e_cur.lat);
        check_eq("main_busy_in_done", m_busy, 0);
        if (e_cur.same) check_eq("main_counts_equal", m_cnt_a, m_cnt_b);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, edges=%0d expected < 10000", edge_n);
    $fatal(1);
  end

  initial begin
    int n;
    rst_n = 1'b0; ena = 1'b0; start = 1'b0;
    sel_a = '0; sel_b = '0; window = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", m_busy, 0);
    check_eq("rst_valid", m_valid, 0);
    check_eq("rst_response", m_resp, 0);
    check_eq("rst_tie", m_tie, 0);
    check_eq("rst_count_a", m_cnt_a, 0);
    check_eq("rst_count_b", m_cnt_b, 0);
    rst_n = 1'b1;
    ena   = 1'b1;
    repeat (2) @(negedge clk);

    // Reference challenge: fast RO3 against slow RO5.
    kick(3, 5, 100);
    push_main(3, 5, 100);
    @(negedge clk);
    check_eq("busy_after_start", m_busy, 1);
    n = 0;
    while (!o_valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    check_eq("one_valid_seen", o_valid, 1);
    check_eq("one_latency", edge_n - acc, 105);
    check_eq("one_count_a_25pm1", (o_cnt_a >= 24 && o_cnt_a <= 26), 1);
    check_eq("one_count_b_12pm1", (o_cnt_b >= 11 && o_cnt_b <= 13), 1);
    check_eq("one_response", o_resp, 1);
    check_eq("one_tie", o_tie, 0);
    check_eq("sat_count_a", s_cnt_a, 15);
    check_eq("sat_response", s_resp, 1);
    drain(1000);

    // Index wrap across the bank.
    kick(15, 14, 400);
    push_main(15, 14, 400);
    drain(3500);

    // Abort during pair 2 MEASURE keeps the previous response.
    kick(0, 1, 50);
    repeat (130) @(negedge clk);
    ena = 1'b0;
    @(negedge clk);
    check_eq("abort_busy", m_busy, 0);
    check_eq("abort_valid", m_valid, 0);
    check_eq("abort_response", m_resp, model(15, 14));
    check_eq("abort_tie", m_tie, 0);
    repeat (5) @(negedge clk);
    ena = 1'b1;
    kick(8, 9, 200);
    push_main(8, 9, 200);
    drain(1800);

    // Same oscillator on both channels, with a start pulse while busy.
    kick(7, 7, 20);
    push_main(7, 7, 20);
    repeat (50) @(negedge clk);
    sel_a  = 4'd1;
    sel_b  = 4'd2;
    window = 12'd5;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain(300);
    repeat (250) @(negedge clk);
    check_eq("idle_after_busy_start", m_busy, 0);

    // Zero window behaves as one clock.
    kick(2, 2, 0);
    push_main(2, 2, 0);
    drain(100);

    // Reset in the middle of MEASURE.
    kick(3, 5, 100);
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("midrst_busy", m_busy, 0);
    check_eq("midrst_valid", m_valid, 0);
    check_eq("midrst_response", m_resp, 0);
    check_eq("midrst_tie", m_tie, 0);
    check_eq("midrst_count_a", m_cnt_a, 0);
    check_eq("midrst_count_b", m_cnt_b, 0);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
